// File: rtl/instruction_decode.sv
// MIPS ID stage: register file, beq/j resolution toward fetch, and the ID/EX pipeline register.
// jump/branch and their targets are combinational on IR/PC; ex_* register on posedge (1 cycle).
// Same-cycle writeback forwarding to the read ports when ID_WB_BYPASS_EN is defined.
module instruction_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic [31:0] PC,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        jump,
  output logic        branch,
  output logic [31:0] jump_addr,
  output logic [31:0] branch_addr,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dst,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [31:0] regs_q [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [31:0] imm_ext;
  logic [31:0] rs_val, rt_val;
  logic        wb_hit;

  logic [4:0]  dst_d;
  logic [2:0]  alu_op_d;
  logic        alu_src_d, reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d;
  logic        is_beq, is_j;

  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]  dst_q;
  logic [2:0]  alu_op_q;
  logic        alu_src_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;

  assign opcode  = IR[31:26];
  assign funct   = IR[5:0];
  assign rs_idx  = IR[25:21];
  assign rt_idx  = IR[20:16];
  assign rd_idx  = IR[15:11];
  assign imm_ext = {{16{IR[15]}}, IR[15:0]};
  assign wb_hit  = wb_we && (wb_addr != 5'd0);

  // Register file: async clear to program constants, write on posedge; $0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      regs_q[1] <= 32'd1;
      regs_q[2] <= 32'd2;
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Read ports, optionally forwarding the writeback landing this cycle
  always_comb begin
    rs_val = (rs_idx == 5'd0) ? 32'd0 : regs_q[rs_idx];
    rt_val = (rt_idx == 5'd0) ? 32'd0 : regs_q[rt_idx];
`ifdef ID_WB_BYPASS_EN
    if (wb_hit && (wb_addr == rs_idx)) rs_val = wb_data;
    if (wb_hit && (wb_addr == rt_idx)) rt_val = wb_data;
`endif
  end

  // Opcode/funct decode into next-state ID/EX control; anything unlisted is a bubble
  always_comb begin
    dst_d        = 5'd0;
    alu_op_d     = ALU_ADD;
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    is_beq       = 1'b0;
    is_j         = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        dst_d       = rd_idx;
        case (funct)
          6'b100000: alu_op_d = ALU_ADD;
          6'b100010: alu_op_d = ALU_SUB;
          6'b100100: alu_op_d = ALU_AND;
          6'b100101: alu_op_d = ALU_OR;
          6'b101010: alu_op_d = ALU_SLT;
          default: begin
            reg_write_d = 1'b0;
            dst_d       = 5'd0;
          end
        endcase
      end
      OP_LW: begin
        alu_src_d    = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
        dst_d        = rt_idx;
      end
      OP_SW: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      OP_BEQ:  is_beq = 1'b1;
      OP_J:    is_j   = 1'b1;
      default: ;
    endcase
  end

  assign jump        = is_j;
  assign branch      = is_beq && (rs_val == rt_val);
  assign jump_addr   = {PC[31:28], IR[25:0], 2'b00};
  assign branch_addr = PC + {imm_ext[29:0], 2'b00};

  // ID/EX pipeline register, cleared asynchronously and held at zero while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q    <= 32'd0;
      rt_data_q    <= 32'd0;
      imm_q        <= 32'd0;
      dst_q        <= 5'd0;
      alu_op_q     <= 3'd0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      rs_data_q    <= rs_val;
      rt_data_q    <= rt_val;
      imm_q        <= imm_ext;
      dst_q        <= dst_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_dst        = dst_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboarded bench for instruction_decode: directed cases then random instructions.
// A driver pushes expected results at negedge; a monitor pops and compares at posedge+1.
// Expectations come from an array register-file model and a mnemonic-level decoder.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR, PC;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        jump, branch;
  logic [31:0] jump_addr, branch_addr;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_dst;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  instruction_decode dut (
    .clk(clk), .rst(rst), .IR(IR), .PC(PC),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump(jump), .branch(branch), .jump_addr(jump_addr), .branch_addr(branch_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_dst(ex_dst), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jump, branch;
    logic [31:0] jaddr, baddr, rs, rt, imm;
    logic [4:0]  dst;
    logic [2:0]  op;
    logic        src, rw, mr, mw, m2r;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rf [32];
  int          errors = 0;
  int          checks = 0;
  bit          drv_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 0;
    model_rf[1] = 1;
    model_rf[2] = 2;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 0) return 0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return model_rf[idx];
  endfunction

  // Decoder written per mnemonic, with addresses computed arithmetically
  function automatic exp_t model_decode(input logic [31:0] ir, input logic [31:0] pc,
                                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    int   off;
    off   = int'($signed(ir[15:0]));
    e     = '{default: '0};
    e.rs  = model_read(ir[25:21], we, wa, wd);
    e.rt  = model_read(ir[20:16], we, wa, wd);
    e.imm = off;
    e.jaddr = (pc & 32'hF000_0000) + (ir & 32'h03FF_FFFF) * 4;
    e.baddr = pc + off * 4;
    case (ir[31:26])
      6'd0: begin
        case (ir[5:0])
          6'd32: e.op = 0;
          6'd34: e.op = 1;
          6'd36: e.op = 2;
          6'd37: e.op = 3;
          6'd42: e.op = 4;
          default: e.op = 7;
        endcase
        if (e.op != 7) begin
          e.rw  = 1;
          e.dst = ir[15:11];
        end else e.op = 0;
      end
      6'd35: begin e.src = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.dst = ir[20:16]; end
      6'd43: begin e.src = 1; e.mw = 1; end
      6'd4:  e.branch = (e.rs == e.rt);
      6'd2:  e.jump = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input logic [31:0] ir, input logic [31:0] pc,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    IR = ir; PC = pc; wb_we = we; wb_addr = wa; wb_data = wd;
    sb_q.push_back(model_decode(ir, pc, we, wa, wd));
    if (we && wa != 0) model_rf[wa] = wd;
  endtask

  task automatic check_ex_zero(input string tag);
    check({tag, " rs_data"}, ex_rs_data, 0);
    check({tag, " rt_data"}, ex_rt_data, 0);
    check({tag, " imm"}, ex_imm, 0);
    check({tag, " ctrl"}, {ex_dst, ex_alu_op, ex_alu_src, ex_reg_write,
                           ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    return w;
  endfunction

  // Monitor: compare every presented output against the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("jump", jump, e.jump);
        check("branch", branch, e.branch);
        if (e.jump) check("jump_addr", jump_addr, e.jaddr);
        check("branch_addr", branch_addr, e.baddr);
        check("ex_rs_data", ex_rs_data, e.rs);
        check("ex_rt_data", ex_rt_data, e.rt);
        check("ex_imm", ex_imm, e.imm);
        check("ex_dst", ex_dst, e.dst);
        check("ex_alu_op", ex_alu_op, e.op);
        check("ex_ctrl", {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
              {e.src, e.rw, e.mr, e.mw, e.m2r});
      end
    end
  end

  // Driver: directed cases, mid-run async reset, then random instructions
  initial begin
    rst = 1'b1; IR = 0; PC = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    #2;
    check_ex_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    step(rtype(1, 2, 10, 32), 32'h4, 0, 0, 0);          // reads $1,$2 after reset
    step(rtype(5, 0, 0, 32), 32'h8, 0, 0, 0);           // $5 reads 0
    step(0, 32'hC, 1, 3, 7);
    step(0, 32'h10, 1, 4, 5);
    step(32'h0064_4822, 32'h14, 1, 9, 2);               // sub $9,$3,$4
    step(32'h1122_FFEA, 32'h44, 0, 0, 0);               // beq $9,$2 taken
    step(0, 32'h48, 1, 9, 3);
    step(32'h1122_FFEA, 32'h44, 0, 0, 0);               // beq not taken
    step(32'h0800_0017, 32'h104, 0, 0, 0);              // j
    step(0, 32'h108, 1, 0, 32'hFFFF);                   // write to $0 dropped
    step(rtype(0, 0, 0, 32), 32'h10C, 0, 0, 0);
    step(rtype(3, 4, 9, 34), 32'h110, 1, 3, 32'hAB);    // same-cycle write of $3
    step(rtype(3, 0, 8, 37), 32'h114, 0, 0, 0);
    step(32'hFC00_0000, 32'h118, 0, 0, 0);              // illegal opcode
    step(rtype(3, 4, 12, 63), 32'h11C, 0, 0, 0);        // unlisted funct

    // Async reset between edges with a non-zero pipeline register
    step(32'h8C65_1234, 32'h120, 0, 0, 0);              // lw leaves ex_* non-zero
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_ex_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 check_ex_zero("rst_hold");
    @(negedge clk) rst = 1'b0;
    step(rtype(3, 2, 11, 42), 32'h200, 0, 0, 0);        // $3 cleared, $2 constant

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ir;
      int rs, rt, rd, kind;
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 31);
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1: begin
          int fsel;
          fsel = $urandom_range(0, 4);
          ir = rtype(rs, rt, rd, (fsel == 0) ? 32 : (fsel == 1) ? 34 : (fsel == 2) ? 36 :
                                 (fsel == 3) ? 37 : 42);
        end
        2: ir = {6'd35, 5'(rs), 5'(rt), 16'($urandom)};
        3: ir = {6'd43, 5'(rs), 5'(rt), 16'($urandom)};
        4: ir = {6'd4, 5'(rs), ($urandom_range(0, 1) == 1) ? 5'(rs) : 5'(rt), 16'($urandom)};
        5: ir = {6'd2, 26'($urandom)};
        6: ir = rtype(rs, rt, rd, $urandom_range(0, 63));
        default: ir = $urandom;
      endcase
      step(ir, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    drv_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    if (!drv_done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the lab-4 MIPS core, directly downstream of instruction fetch. It takes the fetched IR and its PC (already incremented by 4), reads the 32×32 register file, and resolves beq/j in this stage, driving jump/branch and their target addresses back to fetch. It registers decoded operands and control into the ID/EX pipeline register for execute. Writeback from the last stage enters through a dedicated register-file write port.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register index.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- IR  in  32  instruction from fetch.
- PC  in  32  fetch PC, equal to the IR address + 4.
- wb_we  in  1  register-file write enable from writeback.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- jump  out  1  combinational; IR is j.
- branch  out  1  combinational; IR is beq and operands are equal.
- jump_addr  out  32  combinational; {PC[31:28], IR[25:0], 2'b00}.
- branch_addr  out  32  combinational; PC + (sign_ext(IR[15:0]) << 2), modulo 2^32.
- ex_rs_data, ex_rt_data  out  32 each  registered operands.
- ex_imm  out  32  registered sign-extended IR[15:0].
- ex_dst  out  5  registered destination: rd for R-type, rt for lw, 0 otherwise.
- ex_alu_op  out  3  registered: 0 add, 1 sub, 2 and, 3 or, 4 slt.
- ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control.

## Operation
- Decode by IR[31:26]:
  - 000000 R-type. The funct field selects the ALU op: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. reg_write=1, alu_src=0.
  - 100011 lw: alu_op add, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
  - 101011 sw: alu_op add, alu_src=1, mem_write=1.
  - 000100 beq: branch = (rs_val == rt_val). Nothing is written downstream; ID/EX control is all zero.
  - 000010 j: jump=1; ID/EX control is all zero.
  - Any other opcode, or an unlisted R-type funct, decodes as a bubble: all ID/EX control 0, ex_dst 0, jump/branch 0.
- Register file, 32×32:
  - Reads are combinational on IR[25:21] and IR[20:16].
  - Register 0 always reads 0. Writes to it are discarded.
  - A write occurs on posedge clk when wb_we=1 and wb_addr≠0.
- jump and branch are never both 1, since the opcodes are exclusive.
- Fetch uses the instruction following a taken branch or jump as a delay slot. This stage does not squash it; software fills it with NOPs.
- On reset, all registers are cleared except $1=1 and $2=2 (program constants). All ID/EX outputs reset to 0.

## Timing
- jump, branch, jump_addr and branch_addr are valid in the same cycle IR is presented. Fetch samples them at the next posedge.
- ID/EX outputs have 1-cycle latency: the IR decoded in cycle n appears on ex_* after posedge n+1.
- rst asserted mid-operation clears the ID/EX register and register file immediately, without waiting for clk. While rst is high, ex_* hold 0.
- A writeback and a read of the same register in the same cycle is governed by the configuration macro below.
- branch_addr wraps modulo 2^32. A negative offset past 0 wraps to high addresses.

## Configuration
- ID_WB_BYPASS_EN defined: when wb_we=1, wb_addr≠0 and wb_addr matches a read index, that read port returns wb_data in the same cycle. This applies to both the beq compare and the ex_*_data capture.
- ID_WB_BYPASS_EN undefined: the read returns the pre-write value. Software must separate a producer and its consumer by 3 NOPs.

## Test plan
- Reset: pulse rst asynchronously mid-cycle.
  - All ex_* become 0 immediately.
  - Reading $1 gives 1, $2 gives 2, $5 gives 0.
- R-type: write $3=7 and $4=5 via the WB port, then IR = sub $9,$3,$4 (0x00644822).
  - Next cycle: ex_rs_data=7, ex_rt_data=5, ex_dst=9, ex_alu_op=1, ex_reg_write=1, ex_alu_src=0.
- beq: $9=$2=2, PC=0x44, IR imm=0xFFEA.
  - branch=1, branch_addr=0x44-88=0xFFFFFFEC, ex control all 0.
  - With $9=3: branch=0.
- Jump: IR=0x08000017, PC=0x104.
  - jump=1, jump_addr=0x5C, branch=0.
- Writes: wb_we=1 with wb_addr=0 and data 0xFFFF.
  - $0 still reads 0.
  - Same-cycle write $3=0xAB while IR reads $3: result is 0xAB when ID_WB_BYPASS_EN is defined, the old value otherwise.
- Illegal opcode: IR=0xFC000000.
  - ex control all 0, ex_dst=0, jump=branch=0.
